// File: rtl/spi_byte.sv
// SPI mode-0 byte-wide slave: synchronizes the SPI pins into clk, shifts one byte in and
// one byte out MSB first, and flags each completed byte with done.
module spi_byte (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_rx,
   output logic       spi_tx,
   input  logic [7:0] tx,
   output logic [7:0] rx,
   output logic       done
);

   logic [1:0] sclk_sync_r;
   logic [1:0] cs_sync_r;
   logic [1:0] rx_sync_r;
   logic       sclk_prev_r;
   logic       cs_prev_r;

   logic [2:0] bit_idx_r;
   logic [7:0] rx_shift_r;
   logic [7:0] tx_shift_r;
   logic [7:0] rx_r;
   logic       done_r;

   logic       sclk_rise_s;
   logic       sclk_fall_s;
   logic       cs_rise_s;
   logic       cs_active_s;

   // Two-flop synchronizers plus one history flop each for edge detection.
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_sync_r <= 2'b00;
         cs_sync_r   <= 2'b11;
         rx_sync_r   <= 2'b00;
         sclk_prev_r <= 1'b0;
         cs_prev_r   <= 1'b1;
      end else begin
         sclk_sync_r <= {sclk_sync_r[0], spi_sclk};
         cs_sync_r   <= {cs_sync_r[0], spi_cs_n};
         rx_sync_r   <= {rx_sync_r[0], spi_rx};
         sclk_prev_r <= sclk_sync_r[1];
         cs_prev_r   <= cs_sync_r[1];
      end
   end

   // Edge detection on the synchronized pins.
   always_comb begin
      sclk_rise_s = sclk_sync_r[1] & ~sclk_prev_r;
      sclk_fall_s = ~sclk_sync_r[1] & sclk_prev_r;
      cs_rise_s   = cs_sync_r[1] & ~cs_prev_r;
      cs_active_s = ~cs_sync_r[1];
   end

   // Byte engine: a cs deassert outranks any sclk edge seen in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         bit_idx_r  <= 3'd0;
         rx_shift_r <= 8'h00;
         tx_shift_r <= 8'h00;
         rx_r       <= 8'h00;
         done_r     <= 1'b1;
      end else if (cs_rise_s) begin
         bit_idx_r  <= 3'd0;
         rx_shift_r <= 8'h00;
         tx_shift_r <= 8'h00;
         done_r     <= 1'b0;
      end else if (!cs_active_s) begin
         bit_idx_r  <= 3'd0;
      end else if (sclk_rise_s) begin
         rx_shift_r <= {rx_shift_r[6:0], rx_sync_r[1]};
         done_r     <= 1'b0;
         if (bit_idx_r == 3'd0) begin
            tx_shift_r <= tx;
         end else begin
            tx_shift_r <= tx_shift_r;
         end
      end else if (sclk_fall_s) begin
         bit_idx_r  <= bit_idx_r + 3'd1;
         tx_shift_r <= {tx_shift_r[6:0], 1'b0};
         if (bit_idx_r == 3'd7) begin
            rx_r   <= rx_shift_r;
            done_r <= 1'b1;
         end else begin
            rx_r   <= rx_r;
            done_r <= done_r;
         end
      end else begin
         bit_idx_r <= bit_idx_r;
      end
   end

   // At bit 0 the MSB comes straight from tx so it is valid before the first rising edge.
   always_comb begin
      spi_tx = 1'b0;
      if (!cs_active_s) begin
         spi_tx = 1'b0;
      end else if (bit_idx_r == 3'd0) begin
         spi_tx = tx[7];
      end else begin
         spi_tx = tx_shift_r[7];
      end
   end

   assign rx   = rx_r;
   assign done = done_r;

endmodule

// File: tb/tb_spi_byte.sv
// Full-duplex loopback bench: two spi_byte instances share sclk/cs_n and cross their
// serial lines; expected values come from the bytes each side hands in.
module tb_spi_byte;

   logic       clk = 1'b0;
   logic       reset;
   logic       spi_sclk;
   logic       spi_cs_n;
   logic [7:0] tx_a, tx_b;
   logic [7:0] rx_a, rx_b;
   logic       spi_tx_a, spi_tx_b;
   logic       done_a, done_b;

   int checks = 0;
   int passed = 0;

   // Model: each side's rx is the last full byte the other side transmitted.
   logic [7:0] exp_rx_a, exp_rx_b;
   logic [7:0] q_to_a[$];
   logic [7:0] q_to_b[$];

   always #5 clk = ~clk;

   spi_byte u_a (
      .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_rx(spi_tx_b), .spi_tx(spi_tx_a), .tx(tx_a), .rx(rx_a), .done(done_a)
   );

   spi_byte u_b (
      .clk(clk), .reset(reset), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_rx(spi_tx_a), .spi_tx(spi_tx_b), .tx(tx_b), .rx(rx_b), .done(done_b)
   );

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Clock nbits bits of ba (from a) and bb (from b), checking spi_tx and done per bit.
   task automatic xfer_bits(input logic [7:0] ba, input logic [7:0] bb, input int nbits);
      logic exp_d;
      tx_a = ba;
      tx_b = bb;
      wait_clks(1);
      for (int i = 0; i < nbits; i++) begin
         checks++;
         if (spi_tx_a !== ba[7-i] || spi_tx_b !== bb[7-i])
            $display("FAIL tx_bit bit %0d: got a=%b b=%b want a=%b b=%b",
                     i, spi_tx_a, spi_tx_b, ba[7-i], bb[7-i]);
         else passed++;
         spi_sclk = 1'b1;
         wait_clks(8);
         spi_sclk = 1'b0;
         wait_clks(5);
         exp_d = (i == 7);
         checks++;
         if (done_a !== exp_d || done_b !== exp_d)
            $display("FAIL done_bit bit %0d: got a=%b b=%b want %b", i, done_a, done_b, exp_d);
         else passed++;
         wait_clks(3);
      end
      if (nbits == 8) begin
         q_to_a.push_back(bb);
         q_to_b.push_back(ba);
         exp_rx_a = q_to_a.pop_front();
         exp_rx_b = q_to_b.pop_front();
         checks++;
         if (rx_a !== exp_rx_a || rx_b !== exp_rx_b)
            $display("FAIL rx_byte: got a=%h b=%h want a=%h b=%h", rx_a, rx_b, exp_rx_a, exp_rx_b);
         else passed++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; spi_sclk = 1'b0; spi_cs_n = 1'b1; tx_a = 8'h00; tx_b = 8'h00;
      wait_clks(4);
      reset = 1'b0;
      wait_clks(1);
      exp_rx_a = 8'h00; exp_rx_b = 8'h00;
      checks++;
      if (done_a !== 1'b1 || done_b !== 1'b1 || rx_a !== 8'h00 || rx_b !== 8'h00)
         $display("FAIL reset_state: got done=%b%b rx=%h/%h want done=11 rx=00/00",
                  done_a, done_b, rx_a, rx_b);
      else passed++;
      checks++;
      if (spi_tx_a !== 1'b0 || spi_tx_b !== 1'b0)
         $display("FAIL reset_tx: got %b%b want 00", spi_tx_a, spi_tx_b);
      else passed++;
      wait_clks(10);
      checks++;
      if (done_a !== 1'b1 || done_b !== 1'b1)
         $display("FAIL idle_done_hold: got %b%b want 11", done_a, done_b);
      else passed++;
   endtask

   task automatic test_cs_pulse;
      spi_cs_n = 1'b0;
      wait_clks(4);
      spi_cs_n = 1'b1;
      wait_clks(6);
      checks++;
      if (done_a !== 1'b0 || done_b !== 1'b0 || rx_a !== exp_rx_a || rx_b !== exp_rx_b)
         $display("FAIL cs_pulse: got done=%b%b rx=%h/%h want done=00 rx=%h/%h",
                  done_a, done_b, rx_a, rx_b, exp_rx_a, exp_rx_b);
      else passed++;
   endtask

   task automatic test_loopback;
      spi_cs_n = 1'b0;
      wait_clks(4);
      xfer_bits(8'hDA, 8'($urandom_range(255, 0)), 8);
      xfer_bits(8'h5B, 8'($urandom_range(255, 0)), 8);
      spi_cs_n = 1'b1;
      wait_clks(6);
      checks++;
      if (done_a !== 1'b0 || done_b !== 1'b0 || rx_b !== 8'h5B || rx_a !== exp_rx_a)
         $display("FAIL end_of_transfer: got done=%b%b rx_b=%h rx_a=%h want done=00 rx_b=5b rx_a=%h",
                  done_a, done_b, rx_b, rx_a, exp_rx_a);
      else passed++;
      checks++;
      if (spi_tx_a !== 1'b0 || spi_tx_b !== 1'b0)
         $display("FAIL idle_tx: got %b%b want 00", spi_tx_a, spi_tx_b);
      else passed++;
   endtask

   task automatic test_abort;
      spi_cs_n = 1'b0;
      wait_clks(4);
      xfer_bits(8'hFF, 8'hFF, 3);
      spi_cs_n = 1'b1;
      wait_clks(6);
      checks++;
      if (done_a !== 1'b0 || done_b !== 1'b0 || rx_a !== exp_rx_a || rx_b !== exp_rx_b)
         $display("FAIL abort: got done=%b%b rx=%h/%h want done=00 rx=%h/%h",
                  done_a, done_b, rx_a, rx_b, exp_rx_a, exp_rx_b);
      else passed++;
      spi_cs_n = 1'b0;
      wait_clks(4);
      xfer_bits(8'h81, 8'($urandom_range(255, 0)), 8);
      checks++;
      if (rx_b !== 8'h81 || done_b !== 1'b1)
         $display("FAIL after_abort: got rx=%h done=%b want rx=81 done=1", rx_b, done_b);
      else passed++;
      spi_cs_n = 1'b1;
      wait_clks(6);
   endtask

   task automatic test_mid_reset;
      spi_cs_n = 1'b0;
      wait_clks(4);
      xfer_bits(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 4);
      reset = 1'b1;
      wait_clks(2);
      reset = 1'b0;
      wait_clks(1);
      exp_rx_a = 8'h00; exp_rx_b = 8'h00;
      checks++;
      if (done_a !== 1'b1 || done_b !== 1'b1 || rx_a !== 8'h00 || rx_b !== 8'h00)
         $display("FAIL mid_reset: got done=%b%b rx=%h/%h want done=11 rx=00/00",
                  done_a, done_b, rx_a, rx_b);
      else passed++;
      wait_clks(4);
      xfer_bits(8'h3C, 8'($urandom_range(255, 0)), 8);
      checks++;
      if (rx_b !== 8'h3C)
         $display("FAIL post_reset_byte: got %h want 3c", rx_b);
      else passed++;
      spi_cs_n = 1'b1;
      wait_clks(6);
   endtask

   task automatic test_cs_sclk_race;
      spi_cs_n = 1'b0;
      wait_clks(4);
      xfer_bits(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 2);
      spi_sclk = 1'b1;
      spi_cs_n = 1'b1;
      wait_clks(8);
      spi_sclk = 1'b0;
      wait_clks(8);
      checks++;
      if (done_a !== 1'b0 || done_b !== 1'b0 || rx_a !== exp_rx_a || rx_b !== exp_rx_b)
         $display("FAIL cs_sclk_race: got done=%b%b rx=%h/%h want done=00 rx=%h/%h",
                  done_a, done_b, rx_a, rx_b, exp_rx_a, exp_rx_b);
      else passed++;
      spi_cs_n = 1'b0;
      wait_clks(4);
      xfer_bits(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 8);
      spi_cs_n = 1'b1;
      wait_clks(6);
   endtask

   task automatic test_back_to_back;
      spi_cs_n = 1'b0;
      wait_clks(4);
      xfer_bits(8'hA5, 8'h5A, 8);
      for (int k = 0; k < 6; k++)
         xfer_bits(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 8);
      spi_cs_n = 1'b1;
      wait_clks(6);
      checks++;
      if (done_a !== 1'b0 || rx_a !== exp_rx_a || rx_b !== exp_rx_b)
         $display("FAIL b2b_end: got done=%b rx=%h/%h want done=0 rx=%h/%h",
                  done_a, rx_a, rx_b, exp_rx_a, exp_rx_b);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_cs_pulse();
      test_loopback();
      test_abort();
      test_mid_reset();
      test_cs_sclk_race();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/spi_byte.md
SPI_BYTE -- requirements
Module: spi_byte

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on its rising edge; frequency at least 4x spi_sclk.
REQ-003 reset  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 spi_sclk  input  1  SPI serial clock, idle low (mode 0), asynchronous to clk.
REQ-005 spi_cs_n  input  1  chip select, active low, asynchronous to clk.
REQ-006 spi_rx  input  1  serial data in, sampled on spi_sclk rising edge.
REQ-007 spi_tx  output  1  serial data out, MSB first, changes after spi_sclk falling edge.
REQ-008 tx  input  8  byte to transmit; held stable by the user from before the first rising spi_sclk edge of a byte until done.
REQ-009 rx  output  8  last completely received byte.
REQ-010 done  output  1  byte-complete flag.

Function
REQ-011 spi_sclk, spi_cs_n and spi_rx SHALL each pass through a two-flop synchronizer on clk; edges are detected on the synchronized values.
REQ-012 The block SHALL keep a 3-bit bit index, an 8-bit receive shift register and an 8-bit transmit shift register.
REQ-013 While synchronized spi_cs_n is high, bit index SHALL be held at 0 and all spi_sclk edges SHALL be ignored.
REQ-014 On a detected spi_cs_n rising edge (deassert), done SHALL clear to 0 one clk after detection; rx SHALL be unchanged; a partial byte SHALL be discarded.
REQ-015 On a detected spi_sclk rising edge with cs asserted, the receive shift register SHALL shift left taking synchronized spi_rx into bit 0; if bit index is 0, the transmit shift register SHALL load tx at that edge.
REQ-016 On a detected spi_sclk rising edge with cs asserted, done SHALL clear to 0.
REQ-017 On a detected spi_sclk falling edge with cs asserted, bit index SHALL increment modulo 8 and the transmit shift register SHALL shift left.
REQ-018 When the falling edge takes bit index from 7 to 0, rx SHALL load the 8 received bits and done SHALL go to 1 in the same clk cycle, within 3 clk cycles of the raw spi_sclk falling edge.
REQ-019 done SHALL then stay 1 until the next detected spi_sclk rising edge, cs deassert, or reset.
REQ-020 When bit index is 0 and cs is asserted, spi_tx SHALL equal tx[7] combinationally, so the MSB is valid before the first rising edge; otherwise spi_tx SHALL equal the transmit shift register bit 7.
REQ-021 When synchronized spi_cs_n is high, spi_tx SHALL drive 0.
REQ-022 Bytes SHALL be back-to-back within one cs assertion with no gap bits; bit order MSB first in both directions.
REQ-023 Simultaneous detected cs deassert and sclk edge: cs deassert SHALL win; the sclk edge is ignored.

Reset
REQ-024 On reset, done SHALL be 1, rx 0x00, bit index 0, both shift registers 0x00, and synchronizers set to idle (sclk 0, cs_n 1, rx 0).
REQ-025 Reset SHALL take priority over all other events, including mid-byte; the partial byte is discarded.
REQ-026 After reset with cs_n held high, done SHALL remain 1 until the first cs deassert edge or sclk rising edge.

Verification
REQ-027 Power-on: assert reset, release with cs_n=1 -> done=1, rx=0x00.
REQ-028 Loopback: connect a receiver instance's spi_rx to a transmitter instance's spi_tx. Pulse cs_n low then high -> done=0. Assert cs_n and send tx=0xDA then 0x5B, 8 sclk pulses each -> done=0 after bits 0-6 and 1 after bit 7 of each byte; receiver rx=0xDA after byte 1 and 0x5B after byte 2.
REQ-029 End of transfer: after the second byte, raise cs_n -> both instances show done=0, rx stays 0x5B, spi_tx=0.
REQ-030 Abort: assert cs_n and clock 3 bits of 0xFF, then raise cs_n -> done=0 and rx unchanged. Reassert cs_n and send 0x81 -> rx=0x81, done=1.
REQ-031 Mid-byte reset: apply reset after 4 bits -> done=1, rx=0x00. The next full byte 0x3C with cs asserted -> rx=0x3C.
REQ-032 Transmit timing: with tx=0xA5, before the first sclk rising edge spi_tx=1; after each falling edge spi_tx steps through 0,1,0,0,1,0,1.
